// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Pipeline hazard / stall controller for a 5-stage pipeline.
//               Combines load-use interlock, taken-branch flush and a
//               data-memory wait-state freeze with timeout detection.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               D_Rs/D_Rt/D_UseRs/D_UseRt - decode-stage source operands
//               E_MemRd/E_Rw/E_BrTaken    - execute-stage load/dest/branch
//               M_MemReq/M_MemAck         - memory-stage access handshake
//               PC_Wr/FD_Wr/DE_Wr/EM_Wr   - pipeline register write enables
//               FD_Flush/DE_Flush/MW_Flush - bubble insertion controls
//               StallCnt            - saturating count of stalled cycles
//               MemErr              - sticky memory-timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  D_Rs,
  input  logic [4:0]  D_Rt,
  input  logic        D_UseRs,
  input  logic        D_UseRt,
  input  logic        E_MemRd,
  input  logic [4:0]  E_Rw,
  input  logic        E_BrTaken,
  input  logic        M_MemReq,
  input  logic        M_MemAck,
  output logic        PC_Wr,
  output logic        FD_Wr,
  output logic        DE_Wr,
  output logic        EM_Wr,
  output logic        FD_Flush,
  output logic        DE_Flush,
  output logic        MW_Flush,
  output logic [15:0] StallCnt,
  output logic        MemErr
);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MEMWAIT = 1'b1;

  localparam logic [7:0]  c_wait_max  = 8'hFF;
  localparam logic [15:0] c_stall_max = 16'hFFFF;

  logic [0:0]  state_q,     state_d;
  logic [7:0]  wait_cnt_q,  wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        mem_err_q,   mem_err_d;

  logic w_load_use;
  logic w_freeze;

  // Register 0 is hard-wired zero, so a load targeting it never creates a
  // dependency.
  assign w_load_use = E_MemRd && (E_Rw != 5'd0) &&
                      ((D_UseRs && (E_Rw == D_Rs)) ||
                       (D_UseRt && (E_Rw == D_Rt)));

  // The freeze begins in the very cycle a request goes unacknowledged, and
  // is dropped on the last allowed wait cycle so the pipeline can resume
  // while the timeout is being flagged.
  assign w_freeze = ((state_q == ST_MEMWAIT) && !M_MemAck && (wait_cnt_q != c_wait_max)) ||
                    ((state_q == ST_RUN) && M_MemReq && !M_MemAck);

  // Mealy control outputs, priority: reset, freeze, branch, load-use.
  always_comb begin
    PC_Wr    = 1'b1;
    FD_Wr    = 1'b1;
    DE_Wr    = 1'b1;
    EM_Wr    = 1'b1;
    FD_Flush = 1'b0;
    DE_Flush = 1'b0;
    MW_Flush = 1'b0;
    if (rst) begin
      PC_Wr    = 1'b0;
      FD_Wr    = 1'b0;
      DE_Wr    = 1'b0;
      EM_Wr    = 1'b0;
      FD_Flush = 1'b1;
      DE_Flush = 1'b1;
      MW_Flush = 1'b1;
    end else if (w_freeze) begin
      // Hold every stage; the memory stage drains a bubble into WB.
      PC_Wr    = 1'b0;
      FD_Wr    = 1'b0;
      DE_Wr    = 1'b0;
      EM_Wr    = 1'b0;
      MW_Flush = 1'b1;
    end else if (E_BrTaken) begin
      FD_Flush = 1'b1;
      DE_Flush = 1'b1;
    end else if (w_load_use) begin
      // Hold fetch/decode, let the load advance, insert a bubble into EX.
      PC_Wr    = 1'b0;
      FD_Wr    = 1'b0;
      DE_Flush = 1'b1;
    end
  end

  // Next-state logic for the memory wait FSM and the status registers.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;

    if (state_q == ST_RUN) begin
      if (M_MemReq && !M_MemAck) begin
        state_d    = ST_MEMWAIT;
        wait_cnt_d = 8'd1;
      end
    end else begin
      // M_MemReq is deliberately ignored here: the outstanding access is
      // represented solely by being in this state.
      if (M_MemAck) begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end else if (wait_cnt_q == c_wait_max) begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
        mem_err_d  = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end

    if (!PC_Wr && (stall_cnt_q != c_stall_max)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= 16'd0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign MemErr   = mem_err_q;

endmodule
`default_nettype wire

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port D_Rs, input, 5 bits: Rs of the instruction in the decode stage.
REQ-005 Port D_Rt, input, 5 bits: Rt of the instruction in the decode stage.
REQ-006 Port D_UseRs, input, 1 bit: the decode instruction reads Rs.
REQ-007 Port D_UseRt, input, 1 bit: the decode instruction reads Rt.
REQ-008 Port E_MemRd, input, 1 bit: the execute-stage instruction is a load.
REQ-009 Port E_Rw, input, 5 bits: execute-stage destination register.
REQ-010 Port E_BrTaken, input, 1 bit: the execute-stage branch or jump resolved taken.
REQ-011 Port M_MemReq, input, 1 bit: the memory stage is issuing a data-memory access.
REQ-012 Port M_MemAck, input, 1 bit: data memory completes the access this cycle.
REQ-013 Write enables PC_Wr, FD_Wr, DE_Wr and EM_Wr, outputs, 1 bit each: write enables for PC, IF/ID, ID/EX and EX/MEM.
REQ-014 Flush controls FD_Flush, DE_Flush and MW_Flush, outputs, 1 bit each: load a bubble into IF/ID, ID/EX and MEM/WB.
REQ-015 Port StallCnt, output, 16 bits: count of stalled cycles.
REQ-016 Port MemErr, output, 1 bit: sticky memory-timeout flag.

Function
REQ-017 The block SHALL have two FSM states: RUN and MEMWAIT.
REQ-018 The block SHALL contain an 8-bit wait counter WaitCnt.
REQ-019 Control outputs SHALL be combinational from the current state and the current inputs (Mealy).
REQ-020 Load-use hazard LU SHALL be E_MemRd && E_Rw!=0 && ((D_UseRs && E_Rw==D_Rs) || (D_UseRt && E_Rw==D_Rt)).
REQ-021 Memory freeze FZ SHALL be (state==MEMWAIT && !M_MemAck && WaitCnt!=255) || (state==RUN && M_MemReq && !M_MemAck).
REQ-022 Priority SHALL be FZ, then E_BrTaken, then LU, then normal operation.
REQ-023 When FZ is asserted: PC_Wr=FD_Wr=DE_Wr=EM_Wr=0, MW_Flush=1, and FD_Flush=DE_Flush=0.
REQ-024 When E_BrTaken is asserted and FZ is not: all write enables SHALL be 1, FD_Flush=1, DE_Flush=1, MW_Flush=0.
REQ-025 When LU is asserted and neither FZ nor E_BrTaken is: PC_Wr=0, FD_Wr=0, DE_Wr=1, EM_Wr=1, DE_Flush=1, and the other flushes 0.
REQ-026 The LU stall SHALL last exactly one cycle for a single load-use pair.
REQ-027 In normal operation all write enables SHALL be 1 and all flushes 0.
REQ-028 Transition RUN->MEMWAIT SHALL occur when M_MemReq && !M_MemAck; WaitCnt SHALL be loaded with 1.
REQ-029 In RUN with M_MemReq && M_MemAck, the FSM SHALL stay in RUN with no freeze (zero-wait access).
REQ-030 In MEMWAIT with M_MemAck: the freeze SHALL release that cycle and the next state SHALL be RUN.
REQ-031 In MEMWAIT without M_MemAck and WaitCnt<255, WaitCnt SHALL increment and the FSM SHALL stay in MEMWAIT.
REQ-032 In MEMWAIT with WaitCnt==255 and no ack: the freeze SHALL release that cycle, MemErr SHALL set at the next edge, and the next state SHALL be RUN.
REQ-033 MemErr SHALL stay set until rst.
REQ-034 M_MemReq SHALL be ignored while in MEMWAIT; the pending access is tracked only by the state.
REQ-035 StallCnt SHALL increment at each edge where PC_Wr==0 and rst==0.
REQ-036 StallCnt SHALL saturate at 16'hFFFF.
REQ-037 Simultaneous LU and FZ SHALL produce the FZ response; LU is re-evaluated once the freeze releases.

Reset
REQ-038 While rst=1, outputs SHALL be PC_Wr=FD_Wr=DE_Wr=EM_Wr=0 and FD_Flush=DE_Flush=MW_Flush=1.
REQ-039 At a rising edge with rst=1: state=RUN, WaitCnt=0, StallCnt=0, MemErr=0.
REQ-040 Reset asserted mid-MEMWAIT SHALL abort the wait; the FSM SHALL be in RUN on the first cycle after rst falls.
REQ-041 StallCnt SHALL NOT count reset cycles.

Verification
REQ-042 E_MemRd=1, E_Rw=8, D_Rs=8, D_UseRs=1 for one cycle -> PC_Wr=0, FD_Wr=0, DE_Flush=1 for exactly 1 cycle; StallCnt=1.
REQ-043 Same pattern with E_Rw=0, or with D_UseRs=0 -> no stall, all enables 1.
REQ-044 E_BrTaken=1 together with LU inputs -> FD_Flush=1, DE_Flush=1, PC_Wr=1; StallCnt unchanged.
REQ-045 M_MemReq=1 with M_MemAck low for 3 cycles, then high -> 3 frozen cycles with MW_Flush=1, release on the ack cycle; StallCnt=3; state returns to RUN.
REQ-046 M_MemReq=1 with M_MemAck held 0 -> 255 frozen cycles, release on cycle 256, then MemErr=1 held until rst.
REQ-047 rst pulsed during MEMWAIT -> reset output values during the pulse, then RUN with StallCnt=0 and MemErr=0.
